// File: rtl/time_keeper_pkg.sv
// rtl/time_keeper_pkg.sv - shared clock types: entry FSM states, BCD HHMM layout, time validity
package time_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } entry_state_e;

  typedef struct packed {
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } hhmm_t;

  localparam logic [2:0] DIGITS_PER_ENTRY = 3'd4;
  localparam logic [5:0] SECONDS_LAST     = 6'd59;

  function automatic logic hhmm_valid(input hhmm_t t);
    return (t.ms_hour <= 4'd2) && (t.ls_hour <= 4'd9) &&
           (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9) &&
           !((t.ms_hour == 4'd2) && (t.ls_hour > 4'd3));
  endfunction

endpackage

// File: rtl/bcd_minute_inc.sv
// rtl/bcd_minute_inc.sv - combinational BCD HHMM plus one minute, 23:59 wraps to 00:00
module bcd_minute_inc
  import time_keeper_pkg::*;
(
  input  logic [15:0] time_i,
  output logic [15:0] time_o
);

  hhmm_t t;
  hhmm_t n;

  assign t = hhmm_t'(time_i);

  always_comb begin
    n = t;
    if (t.ls_min != 4'd9) begin
      n.ls_min = t.ls_min + 4'd1;
    end else begin
      n.ls_min = 4'd0;
      if (t.ms_min != 4'd5) begin
        n.ms_min = t.ms_min + 4'd1;
      end else begin
        n.ms_min = 4'd0;
        if ((t.ms_hour == 4'd2) && (t.ls_hour == 4'd3)) begin
          n.ms_hour = 4'd0;
          n.ls_hour = 4'd0;
        end else if (t.ls_hour == 4'd9) begin
          n.ls_hour = 4'd0;
          n.ms_hour = t.ms_hour + 4'd1;
        end else begin
          n.ls_hour = t.ls_hour + 4'd1;
        end
      end
    end
  end

  assign time_o = n;

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - time-of-day counter with keypad entry buffer and time/alarm loading
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int          TIMEOUT_SECS = 10,
  parameter logic [15:0] ALARM_RESET  = 16'h0600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        load_time,
  input  logic        load_alarm,
  output logic [15:0] current_time,
  output logic [15:0] alarm_time,
  output logic [15:0] key_buffer,
  output logic        entry_active,
  output logic        one_minute,
  output logic        load_error,
  output logic [1:0]  debug_state
);

  localparam int TW = (TIMEOUT_SECS < 2) ? 1 : $clog2(TIMEOUT_SECS);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_SECS - 1);

  entry_state_e  state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [5:0]    sec_q, sec_d;
  logic [15:0]   cur_q, cur_d;
  logic [15:0]   alarm_q, alarm_d;
  logic          one_minute_q, one_minute_d;
  logic          load_error_q, load_error_d;

  logic [15:0] cur_inc;
  logic        load;
  logic        digit_ok;
  logic        load_ok;

  bcd_minute_inc u_minute_inc (
    .time_i (cur_q),
    .time_o (cur_inc)
  );

  assign load     = load_time | load_alarm;
  assign digit_ok = key_valid && (key_digit <= 4'd9);
  assign load_ok  = (cnt_q != 3'd0) && hhmm_valid(hhmm_t'(buf_q));

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    sec_d        = sec_q;
    cur_d        = cur_q;
    alarm_d      = alarm_q;
    one_minute_d = 1'b0;
    load_error_d = 1'b0;

    if (load) begin
      // A load swallows any same-cycle tick and digit.
      state_d = ST_IDLE;
      buf_d   = 16'h0000;
      cnt_d   = 3'd0;
      tmo_d   = '0;
      if (!load_ok) begin
        load_error_d = 1'b1;
      end else if (load_time) begin
        cur_d = buf_q;
        sec_d = 6'd0;
      end else begin
        alarm_d = buf_q;
      end
    end else begin
      if (one_second) begin
        if (sec_q == SECONDS_LAST) begin
          sec_d        = 6'd0;
          cur_d        = cur_inc;
          one_minute_d = 1'b1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end

      case (state_q)
        ST_IDLE, ST_ENTRY: begin
          if (digit_ok) begin
            buf_d   = {buf_q[11:0], key_digit};
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_d == DIGITS_PER_ENTRY) ? ST_FULL : ST_ENTRY;
          end
        end
        ST_FULL: ;
        default: state_d = ST_IDLE;
      endcase

      // Keypad activity restarts the inactivity window; ticks only count while an entry is open.
      if (state_q != ST_IDLE) begin
        if (digit_ok) begin
          tmo_d = '0;
        end else if (one_second) begin
          if (tmo_q == TIMEOUT_LAST) begin
            state_d = ST_IDLE;
            buf_d   = 16'h0000;
            cnt_d   = 3'd0;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_q        <= 16'h0000;
      cnt_q        <= 3'd0;
      tmo_q        <= '0;
      sec_q        <= 6'd0;
      cur_q        <= 16'h0000;
      alarm_q      <= ALARM_RESET;
      one_minute_q <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      sec_q        <= sec_d;
      cur_q        <= cur_d;
      alarm_q      <= alarm_d;
      one_minute_q <= one_minute_d;
      load_error_q <= load_error_d;
    end
  end

  assign current_time = cur_q;
  assign alarm_time   = alarm_q;
  assign key_buffer   = buf_q;
  assign entry_active = (state_q != ST_IDLE);
  assign one_minute   = one_minute_q;
  assign load_error   = load_error_q;
  assign debug_state  = state_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed scoreboard bench for time_keeper
module tb_time_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        one_second;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        load_time;
  logic        load_alarm;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic [15:0] key_buffer;
  logic        entry_active;
  logic        one_minute;
  logic        load_error;
  logic [1:0]  debug_state;

  time_keeper dut (
    .clk          (clk),
    .reset        (reset),
    .one_second   (one_second),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .load_time    (load_time),
    .load_alarm   (load_alarm),
    .current_time (current_time),
    .alarm_time   (alarm_time),
    .key_buffer   (key_buffer),
    .entry_active (entry_active),
    .one_minute   (one_minute),
    .load_error   (load_error),
    .debug_state  (debug_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cur;
    logic [15:0] alm;
    logic [15:0] kb;
    logic [1:0]  st;
    logic        om;
    logic        le;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
    reset      = 1'b0;
    one_second = 1'b0;
    key_valid  = 1'b0;
    key_digit  = 4'd0;
    load_time  = 1'b0;
    load_alarm = 1'b0;
  endtask

  task automatic tick();
    one_second = 1'b1;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
  endtask

  task automatic cmp(input string tag, input string field, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s.%s got=%h expected=%h", tag, field, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] cur, input logic [15:0] alm,
                      input logic [15:0] kb, input logic [1:0] st, input logic om, input logic le);
    exp_t e;
    e.cur = cur; e.alm = alm; e.kb = kb; e.st = st; e.om = om; e.le = le;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp(t, "current_time", current_time, e.cur);
    cmp(t, "alarm_time", alarm_time, e.alm);
    cmp(t, "key_buffer", key_buffer, e.kb);
    cmp(t, "debug_state", {14'd0, debug_state}, {14'd0, e.st});
    cmp(t, "entry_active", {15'd0, entry_active}, {15'd0, (e.st != 2'd0)});
    cmp(t, "one_minute", {15'd0, one_minute}, {15'd0, e.om});
    cmp(t, "load_error", {15'd0, load_error}, {15'd0, e.le});
  endtask

  task automatic expect_out(input string tag, input logic [15:0] cur, input logic [15:0] alm,
                            input logic [15:0] kb, input logic [1:0] st, input logic om, input logic le);
    push(tag, cur, alm, kb, st, om, le);
    check();
  endtask

  initial begin
    reset = 1'b1; one_second = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    load_time = 1'b0; load_alarm = 1'b0;
    step();
    expect_out("reset", 16'h0000, 16'h0600, 16'h0000, 2'd0, 1'b0, 1'b0);

    load_time = 1'b1; step();
    expect_out("load_empty", 16'h0000, 16'h0600, 16'h0000, 2'd0, 1'b0, 1'b1);
    step();
    expect_out("err_one_cycle", 16'h0000, 16'h0600, 16'h0000, 2'd0, 1'b0, 1'b0);

    // 23:59 rollover
    key(4'd2);
    expect_out("first_digit", 16'h0000, 16'h0600, 16'h0002, 2'd1, 1'b0, 1'b0);
    key(4'd3); key(4'd5); key(4'd9);
    expect_out("full_2359", 16'h0000, 16'h0600, 16'h2359, 2'd2, 1'b0, 1'b0);
    load_time = 1'b1; step();
    expect_out("load_2359", 16'h2359, 16'h0600, 16'h0000, 2'd0, 1'b0, 1'b0);
    ticks(59);
    expect_out("pre_wrap", 16'h2359, 16'h0600, 16'h0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("wrap_0000", 16'h0000, 16'h0600, 16'h0000, 2'd0, 1'b1, 1'b0);
    step();
    expect_out("pulse_end", 16'h0000, 16'h0600, 16'h0000, 2'd0, 1'b0, 1'b0);

    // alarm 07:30
    key(4'd0); key(4'd7); key(4'd3);
    expect_out("entry_073", 16'h0000, 16'h0600, 16'h0073, 2'd1, 1'b0, 1'b0);
    key(4'd0);
    expect_out("full_0730", 16'h0000, 16'h0600, 16'h0730, 2'd2, 1'b0, 1'b0);
    load_alarm = 1'b1; step();
    expect_out("alarm_0730", 16'h0000, 16'h0730, 16'h0000, 2'd0, 1'b0, 1'b0);

    // invalid 24:00, then short entry with seconds already advanced
    ticks(7);
    key(4'd2); key(4'd4); key(4'd0); key(4'd0);
    expect_out("full_2400", 16'h0000, 16'h0730, 16'h2400, 2'd2, 1'b0, 1'b0);
    load_time = 1'b1; step();
    expect_out("bad_2400", 16'h0000, 16'h0730, 16'h0000, 2'd0, 1'b0, 1'b1);
    key(4'd1);
    expect_out("entry_1", 16'h0000, 16'h0730, 16'h0001, 2'd1, 1'b0, 1'b0);
    key(4'd2);
    load_time = 1'b1; step();
    expect_out("load_0012", 16'h0012, 16'h0730, 16'h0000, 2'd0, 1'b0, 1'b0);
    ticks(59);
    expect_out("sec_zeroed", 16'h0012, 16'h0730, 16'h0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("min_0013", 16'h0013, 16'h0730, 16'h0000, 2'd0, 1'b1, 1'b0);
    key(4'hA);
    expect_out("ignore_A", 16'h0013, 16'h0730, 16'h0000, 2'd0, 1'b0, 1'b0);

    // inactivity timeout
    key(4'd5);
    expect_out("entry_5", 16'h0013, 16'h0730, 16'h0005, 2'd1, 1'b0, 1'b0);
    ticks(9);
    expect_out("tmo_9", 16'h0013, 16'h0730, 16'h0005, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("tmo_10", 16'h0013, 16'h0730, 16'h0000, 2'd0, 1'b0, 1'b0);

    // fifth digit ignored in FULL
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    expect_out("full_1234", 16'h0013, 16'h0730, 16'h1234, 2'd2, 1'b0, 1'b0);
    key(4'd5);
    expect_out("full_ignore", 16'h0013, 16'h0730, 16'h1234, 2'd2, 1'b0, 1'b0);
    load_alarm = 1'b1; step();
    expect_out("alarm_1234", 16'h0013, 16'h1234, 16'h0000, 2'd0, 1'b0, 1'b0);

    // hour carry 09:59 -> 10:00
    key(4'd0); key(4'd9); key(4'd5); key(4'd9);
    load_time = 1'b1; step();
    expect_out("load_0959", 16'h0959, 16'h1234, 16'h0000, 2'd0, 1'b0, 1'b0);
    ticks(59);
    tick();
    expect_out("carry_1000", 16'h1000, 16'h1234, 16'h0000, 2'd0, 1'b1, 1'b0);

    // simultaneous load_time, load_alarm and tick at seconds=59
    ticks(59);
    expect_out("sec_59", 16'h1000, 16'h1234, 16'h0000, 2'd0, 1'b0, 1'b0);
    key(4'd1); key(4'd0); key(4'd1); key(4'd5);
    expect_out("full_1015", 16'h1000, 16'h1234, 16'h1015, 2'd2, 1'b0, 1'b0);
    load_time = 1'b1; load_alarm = 1'b1; one_second = 1'b1; step();
    expect_out("load_prio", 16'h1015, 16'h1234, 16'h0000, 2'd0, 1'b0, 1'b0);
    step();
    expect_out("no_late_min", 16'h1015, 16'h1234, 16'h0000, 2'd0, 1'b0, 1'b0);
    ticks(59);
    expect_out("tick_dropped", 16'h1015, 16'h1234, 16'h0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("min_1016", 16'h1016, 16'h1234, 16'h0000, 2'd0, 1'b1, 1'b0);

    // reset mid-entry with a same-cycle load
    key(4'd3); key(4'd2);
    expect_out("entry_32", 16'h1016, 16'h1234, 16'h0032, 2'd1, 1'b0, 1'b0);
    reset = 1'b1; load_time = 1'b1; step();
    expect_out("reset_mid", 16'h0000, 16'h0600, 16'h0000, 2'd0, 1'b0, 1'b0);
    step();
    expect_out("reset_hold", 16'h0000, 16'h0600, 16'h0000, 2'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
